// File: rtl/mem_burst_ctrl_pkg.sv
// Shared state encodings, mode constants and default widths for the burst sequencer.
package mem_burst_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;

endpackage : mem_burst_ctrl_pkg

// File: rtl/mem_burst_ctrl_addr_cnt8.sv
// Loadable, enabled up-counter that sources the memory address; load wins over enable.
module addr_cnt8 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         EN,
  input  logic         load,
  input  logic [W-1:0] CNT_In,
  output logic [W-1:0] CNT
);

  // Count register: synchronous clear, then load, then increment (wraps naturally).
  always_ff @(posedge clk) begin
    if (!res) begin
      CNT <= '0;
    end else if (load) begin
      CNT <= CNT_In;
    end else if (EN) begin
      CNT <= CNT + W'(1);
    end
  end

endmodule : addr_cnt8

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: loads the address counter, walks it one word per beat,
// strobes memory read/write enables and pulses done at the end of the burst.
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rem_q;
  logic              mode_q;
  logic              cnt_load;
  logic              cnt_en;
  logic              beat;

  // Address counter; the FSM guarantees load and enable are mutually exclusive.
  addr_cnt8 #(
    .W (ADDR_W)
  ) u_addr_cnt (
    .clk    (clk),
    .res    (res),
    .EN     (cnt_en),
    .load   (cnt_load),
    .CNT_In (base_addr),
    .CNT    (addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remaining-beat down-counter and latched burst direction.
  always_ff @(posedge clk) begin
    if (!res) begin
      rem_q  <= '0;
      mode_q <= MODE_RD;
    end else if (cnt_load) begin
      rem_q  <= length;
      mode_q <= mode;
    end else if (beat) begin
      rem_q  <= rem_q - ADDR_W'(1);
    end
  end

  // Next-state, counter control and memory strobes; abort silences the cycle.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    beat      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    src_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            cnt_load = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          mem_re    = (mode_q == MODE_RD);
          src_ready = (mode_q == MODE_WR);
          mem_we    = (mode_q == MODE_WR) & src_valid;
          beat      = (mode_q == MODE_WR) ? src_valid : 1'b1;
          cnt_en    = beat;
          if (beat && (rem_q == ADDR_W'(1))) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule : mem_burst_ctrl

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with hand-computed expectations per cycle.
module tb_mem_burst_ctrl;

  logic       clk;
  logic       res;
  logic       start;
  logic       mode;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic       abort;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] addr;
  logic       mem_re;
  logic       mem_we;
  logic       busy;
  logic       done;

  int total;
  int bad;

  mem_burst_ctrl dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .addr      (addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output; called after inputs have settled, mid-cycle.
  task automatic expect_all(input string tag, input logic [7:0] e_addr,
                            input logic e_re, input logic e_we, input logic e_rdy,
                            input logic e_busy, input logic e_done);
    #1;
    chk({tag, ".addr"},      addr,      e_addr);
    chk({tag, ".mem_re"},    {7'd0, mem_re},    {7'd0, e_re});
    chk({tag, ".mem_we"},    {7'd0, mem_we},    {7'd0, e_we});
    chk({tag, ".src_ready"}, {7'd0, src_ready}, {7'd0, e_rdy});
    chk({tag, ".busy"},      {7'd0, busy},      {7'd0, e_busy});
    chk({tag, ".done"},      {7'd0, done},      {7'd0, e_done});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    res = 1'b0; start = 1'b0; mode = 1'b0; base_addr = 8'h00; length = 8'h00;
    abort = 1'b0; src_valid = 1'b0;
    cyc(); cyc();
    expect_all("reset", 8'h00, 0, 0, 0, 0, 0);
    res = 1'b1;
    cyc();
    expect_all("idle0", 8'h00, 0, 0, 0, 0, 0);

    // Read burst base=0x10 length=4.
    start = 1'b1; mode = 1'b0; base_addr = 8'h10; length = 8'd4;
    expect_all("rd.accept", 8'h00, 0, 0, 0, 0, 0);
    cyc(); start = 1'b0;
    expect_all("rd.b0", 8'h10, 1, 0, 0, 1, 0);
    cyc(); expect_all("rd.b1", 8'h11, 1, 0, 0, 1, 0);
    cyc(); expect_all("rd.b2", 8'h12, 1, 0, 0, 1, 0);
    cyc(); expect_all("rd.b3", 8'h13, 1, 0, 0, 1, 0);
    cyc(); expect_all("rd.done", 8'h14, 0, 0, 0, 0, 1);
    cyc(); expect_all("rd.idle", 8'h14, 0, 0, 0, 0, 0);

    // Write burst base=0x20 length=3, src_valid 1,0,1,1.
    start = 1'b1; mode = 1'b1; base_addr = 8'h20; length = 8'd3;
    cyc(); start = 1'b0; mode = 1'b0;
    src_valid = 1'b1; expect_all("wr.c0", 8'h20, 0, 1, 1, 1, 0);
    cyc(); src_valid = 1'b0; expect_all("wr.c1", 8'h21, 0, 0, 1, 1, 0);
    cyc(); src_valid = 1'b1; expect_all("wr.c2", 8'h21, 0, 1, 1, 1, 0);
    cyc(); src_valid = 1'b1; expect_all("wr.c3", 8'h22, 0, 1, 1, 1, 0);
    cyc(); src_valid = 1'b0; expect_all("wr.done", 8'h23, 0, 0, 0, 0, 1);
    cyc(); expect_all("wr.idle", 8'h23, 0, 0, 0, 0, 0);

    // Wrap: read base=0xFE length=4.
    start = 1'b1; mode = 1'b0; base_addr = 8'hFE; length = 8'd4;
    cyc(); start = 1'b0;
    expect_all("wrap.b0", 8'hFE, 1, 0, 0, 1, 0);
    cyc(); expect_all("wrap.b1", 8'hFF, 1, 0, 0, 1, 0);
    cyc(); expect_all("wrap.b2", 8'h00, 1, 0, 0, 1, 0);
    cyc(); expect_all("wrap.b3", 8'h01, 1, 0, 0, 1, 0);
    cyc(); expect_all("wrap.done", 8'h02, 0, 0, 0, 0, 1);
    cyc(); expect_all("wrap.idle", 8'h02, 0, 0, 0, 0, 0);

    // Empty burst: length=0 goes straight to DONE, counter untouched.
    start = 1'b1; mode = 1'b0; base_addr = 8'h55; length = 8'd0;
    cyc(); start = 1'b0;
    expect_all("empty.done", 8'h02, 0, 0, 0, 0, 1);
    cyc(); expect_all("empty.idle", 8'h02, 0, 0, 0, 0, 0);

    // Abort in second cycle of read base=0x40 length=5; start during RUN/DONE ignored.
    start = 1'b1; mode = 1'b0; base_addr = 8'h40; length = 8'd5;
    cyc();
    base_addr = 8'h77; length = 8'd2;
    expect_all("abt.b0", 8'h40, 1, 0, 0, 1, 0);
    cyc(); abort = 1'b1;
    expect_all("abt.abort", 8'h41, 0, 0, 0, 1, 0);
    cyc(); abort = 1'b0;
    expect_all("abt.done", 8'h41, 0, 0, 0, 0, 1);
    cyc();
    expect_all("abt.idle", 8'h41, 0, 0, 0, 0, 0);
    start = 1'b0;
    cyc(); expect_all("abt.hold", 8'h41, 0, 0, 0, 0, 0);

    // Reset mid-burst: read base=0x60 length=5, reset after two beats.
    start = 1'b1; mode = 1'b0; base_addr = 8'h60; length = 8'd5;
    cyc(); start = 1'b0;
    expect_all("rst.b0", 8'h60, 1, 0, 0, 1, 0);
    cyc(); expect_all("rst.b1", 8'h61, 1, 0, 0, 1, 0);
    res = 1'b0;
    cyc(); res = 1'b1;
    expect_all("rst.cleared", 8'h00, 0, 0, 0, 0, 0);
    cyc(); expect_all("rst.nodone", 8'h00, 0, 0, 0, 0, 0);

    // Single-beat read after reset is accepted normally.
    start = 1'b1; mode = 1'b0; base_addr = 8'h08; length = 8'd1;
    cyc(); start = 1'b0;
    expect_all("one.b0", 8'h08, 1, 0, 0, 1, 0);
    cyc(); expect_all("one.done", 8'h09, 0, 0, 0, 0, 1);
    cyc(); expect_all("one.idle", 8'h09, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_burst_ctrl
